// File: rtl/mgmt_tlul_xbar.sv
// mgmt_tlul_xbar
// Single-host TL-UL crossbar for the management core data port. Requests are
// decoded by address and steered to the scratchpad, the UART, or an internal
// error responder. All in-flight requests share one target, so responses come
// back in order without any reordering storage.
module mgmt_tlul_xbar #(
    parameter logic [31:0] ScratchpadBase = 32'h0010_0000,
    parameter logic [31:0] ScratchpadMask = 32'h0000_FFFF,
    parameter logic [31:0] UartBase       = 32'h8000_0000,
    parameter logic [31:0] UartMask       = 32'h0000_0FFF,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned SourceWidth    = 8
) (
    input  logic                   clk_sys_i,
    input  logic                   rst_sys_ni,
    // host port
    input  logic                   host_a_valid,
    input  logic [2:0]             host_a_opcode,
    input  logic [1:0]             host_a_size,
    input  logic [SourceWidth-1:0] host_a_source,
    input  logic [31:0]            host_a_address,
    input  logic [3:0]             host_a_mask,
    input  logic [31:0]            host_a_data,
    output logic                   host_a_ready,
    output logic                   host_d_valid,
    output logic [2:0]             host_d_opcode,
    output logic [1:0]             host_d_size,
    output logic [SourceWidth-1:0] host_d_source,
    output logic [31:0]            host_d_data,
    output logic                   host_d_error,
    input  logic                   host_d_ready,
    // scratchpad data port
    output logic                   spad_a_valid,
    output logic [2:0]             spad_a_opcode,
    output logic [1:0]             spad_a_size,
    output logic [SourceWidth-1:0] spad_a_source,
    output logic [31:0]            spad_a_address,
    output logic [3:0]             spad_a_mask,
    output logic [31:0]            spad_a_data,
    input  logic                   spad_a_ready,
    input  logic                   spad_d_valid,
    input  logic [2:0]             spad_d_opcode,
    input  logic [1:0]             spad_d_size,
    input  logic [SourceWidth-1:0] spad_d_source,
    input  logic [31:0]            spad_d_data,
    input  logic                   spad_d_error,
    output logic                   spad_d_ready,
    // UART
    output logic                   uart_a_valid,
    output logic [2:0]             uart_a_opcode,
    output logic [1:0]             uart_a_size,
    output logic [SourceWidth-1:0] uart_a_source,
    output logic [31:0]            uart_a_address,
    output logic [3:0]             uart_a_mask,
    output logic [31:0]            uart_a_data,
    input  logic                   uart_a_ready,
    input  logic                   uart_d_valid,
    input  logic [2:0]             uart_d_opcode,
    input  logic [1:0]             uart_d_size,
    input  logic [SourceWidth-1:0] uart_d_source,
    input  logic [31:0]            uart_d_data,
    input  logic                   uart_d_error,
    output logic                   uart_d_ready
);

    typedef enum logic [1:0] {
        SelSpad = 2'd0,
        SelUart = 2'd1,
        SelErr  = 2'd2
    } sel_e;

    localparam logic [2:0] OpGet         = 3'd4;
    localparam logic [2:0] OpAccessAck   = 3'd0;
    localparam logic [2:0] OpAccessAckD  = 3'd1;
    localparam int unsigned CntWidth     = $clog2(MaxOutstanding + 1);
    localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxOutstanding);

    sel_e                   tgt;
    sel_e                   cur_sel;
    logic [CntWidth-1:0]    out_cnt;
    logic                   stall;
    logic                   accept;
    logic                   d_hs;
    logic                   err_pend;
    logic                   err_d_ready;
    logic [2:0]             err_opcode;
    logic [1:0]             err_size;
    logic [SourceWidth-1:0] err_source;

    // Non-valid A fields go to both devices unchanged; only a_valid is steered.
    assign spad_a_opcode  = host_a_opcode;
    assign spad_a_size    = host_a_size;
    assign spad_a_source  = host_a_source;
    assign spad_a_address = host_a_address;
    assign spad_a_mask    = host_a_mask;
    assign spad_a_data    = host_a_data;
    assign uart_a_opcode  = host_a_opcode;
    assign uart_a_size    = host_a_size;
    assign uart_a_source  = host_a_source;
    assign uart_a_address = host_a_address;
    assign uart_a_mask    = host_a_mask;
    assign uart_a_data    = host_a_data;

    // Address decode; the scratchpad window takes priority if windows overlap.
    always_comb begin
        tgt = SelErr;
        if ((host_a_address & ~ScratchpadMask) == ScratchpadBase) begin
            tgt = SelSpad;
        end else if ((host_a_address & ~UartMask) == UartBase) begin
            tgt = SelUart;
        end
    end

    // A-channel steering: hold off while full or while the target would change under in-flight requests.
    always_comb begin
        spad_a_valid = 1'b0;
        uart_a_valid = 1'b0;
        host_a_ready = 1'b0;
        stall = (out_cnt == CntMax) || ((out_cnt != '0) && (tgt != cur_sel));
        if (rst_sys_ni && !stall) begin
            case (tgt)
                SelSpad: begin
                    spad_a_valid = host_a_valid;
                    host_a_ready = spad_a_ready;
                end
                SelUart: begin
                    uart_a_valid = host_a_valid;
                    host_a_ready = uart_a_ready;
                end
                default: host_a_ready = !err_pend;
            endcase
        end
    end

    assign accept = host_a_valid && host_a_ready;

    // D-channel return path: only the device owning the in-flight requests is heard or handed d_ready.
    always_comb begin
        host_d_valid  = 1'b0;
        host_d_opcode = OpAccessAck;
        host_d_size   = 2'd0;
        host_d_source = '0;
        host_d_data   = 32'h0;
        host_d_error  = 1'b0;
        spad_d_ready  = 1'b0;
        uart_d_ready  = 1'b0;
        err_d_ready   = 1'b0;
        if (rst_sys_ni && (out_cnt != '0)) begin
            case (cur_sel)
                SelSpad: begin
                    host_d_valid  = spad_d_valid;
                    host_d_opcode = spad_d_opcode;
                    host_d_size   = spad_d_size;
                    host_d_source = spad_d_source;
                    host_d_data   = spad_d_data;
                    host_d_error  = spad_d_error;
                    spad_d_ready  = host_d_ready;
                end
                SelUart: begin
                    host_d_valid  = uart_d_valid;
                    host_d_opcode = uart_d_opcode;
                    host_d_size   = uart_d_size;
                    host_d_source = uart_d_source;
                    host_d_data   = uart_d_data;
                    host_d_error  = uart_d_error;
                    uart_d_ready  = host_d_ready;
                end
                default: begin
                    host_d_valid  = err_pend;
                    host_d_opcode = (err_opcode == OpGet) ? OpAccessAckD : OpAccessAck;
                    host_d_size   = err_size;
                    host_d_source = err_source;
                    host_d_data   = 32'hFFFF_FFFF;
                    host_d_error  = 1'b1;
                    err_d_ready   = host_d_ready;
                end
            endcase
        end
    end

    assign d_hs = host_d_valid && host_d_ready;

    // Outstanding counter and the target that all in-flight requests belong to.
    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            out_cnt <= '0;
            cur_sel <= SelSpad;
        end else begin
            if (accept) begin
                cur_sel <= tgt;
            end
            if (accept && !d_hs) begin
                out_cnt <= out_cnt + CntWidth'(1);
            end else if (!accept && d_hs) begin
                out_cnt <= out_cnt - CntWidth'(1);
            end
        end
    end

    // One-entry error responder: capture the unmapped request, answer it, free on handshake.
    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            err_pend   <= 1'b0;
            err_opcode <= 3'd0;
            err_size   <= 2'd0;
            err_source <= '0;
        end else if (accept && (tgt == SelErr)) begin
            err_pend   <= 1'b1;
            err_opcode <= host_a_opcode;
            err_size   <= host_a_size;
            err_source <= host_a_source;
        end else if (err_pend && err_d_ready) begin
            err_pend   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mgmt_tlul_xbar.sv
// tb_mgmt_tlul_xbar
// Directed scenarios plus a randomized run against an in-order transaction model.
module tb_mgmt_tlul_xbar;

    localparam int MaxOut = 4;
    localparam logic [2:0] OpGet        = 3'd4;
    localparam logic [2:0] OpPutFull    = 3'd0;
    localparam logic [2:0] OpPutPartial = 3'd1;
    localparam logic [2:0] OpAck        = 3'd0;
    localparam logic [2:0] OpAckData    = 3'd1;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] data;
        logic [7:0]  src;
        logic        err;
        logic        chk;
    } rsp_t;

    logic clk_sys_i = 1'b0;
    logic rst_sys_ni;
    logic host_a_valid, host_a_ready, host_d_valid, host_d_error, host_d_ready;
    logic [2:0] host_a_opcode, host_d_opcode;
    logic [1:0] host_a_size, host_d_size;
    logic [7:0] host_a_source, host_d_source;
    logic [31:0] host_a_address, host_a_data, host_d_data;
    logic [3:0] host_a_mask;
    logic spad_a_valid, spad_a_ready, spad_d_valid, spad_d_error, spad_d_ready;
    logic [2:0] spad_a_opcode, spad_d_opcode;
    logic [1:0] spad_a_size, spad_d_size;
    logic [7:0] spad_a_source, spad_d_source;
    logic [31:0] spad_a_address, spad_a_data, spad_d_data;
    logic [3:0] spad_a_mask;
    logic uart_a_valid, uart_a_ready, uart_d_valid, uart_d_error, uart_d_ready;
    logic [2:0] uart_a_opcode, uart_d_opcode;
    logic [1:0] uart_a_size, uart_d_size;
    logic [7:0] uart_a_source, uart_d_source;
    logic [31:0] uart_a_address, uart_a_data, uart_d_data;
    logic [3:0] uart_a_mask;

    int checks = 0;
    int errors = 0;

    always #5 clk_sys_i = ~clk_sys_i;

    mgmt_tlul_xbar dut (
        .clk_sys_i(clk_sys_i), .rst_sys_ni(rst_sys_ni),
        .host_a_valid(host_a_valid), .host_a_opcode(host_a_opcode), .host_a_size(host_a_size),
        .host_a_source(host_a_source), .host_a_address(host_a_address), .host_a_mask(host_a_mask),
        .host_a_data(host_a_data), .host_a_ready(host_a_ready), .host_d_valid(host_d_valid),
        .host_d_opcode(host_d_opcode), .host_d_size(host_d_size), .host_d_source(host_d_source),
        .host_d_data(host_d_data), .host_d_error(host_d_error), .host_d_ready(host_d_ready),
        .spad_a_valid(spad_a_valid), .spad_a_opcode(spad_a_opcode), .spad_a_size(spad_a_size),
        .spad_a_source(spad_a_source), .spad_a_address(spad_a_address), .spad_a_mask(spad_a_mask),
        .spad_a_data(spad_a_data), .spad_a_ready(spad_a_ready), .spad_d_valid(spad_d_valid),
        .spad_d_opcode(spad_d_opcode), .spad_d_size(spad_d_size), .spad_d_source(spad_d_source),
        .spad_d_data(spad_d_data), .spad_d_error(spad_d_error), .spad_d_ready(spad_d_ready),
        .uart_a_valid(uart_a_valid), .uart_a_opcode(uart_a_opcode), .uart_a_size(uart_a_size),
        .uart_a_source(uart_a_source), .uart_a_address(uart_a_address), .uart_a_mask(uart_a_mask),
        .uart_a_data(uart_a_data), .uart_a_ready(uart_a_ready), .uart_d_valid(uart_d_valid),
        .uart_d_opcode(uart_d_opcode), .uart_d_size(uart_d_size), .uart_d_source(uart_d_source),
        .uart_d_data(uart_d_data), .uart_d_error(uart_d_error), .uart_d_ready(uart_d_ready)
    );

    // Watchdog so the run always ends even if the clock flow stalls.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int tb_decode(input logic [31:0] a);
        if (a >= 32'h0010_0000 && a <= 32'h0010_FFFF) return 0;
        if (a >= 32'h8000_0000 && a <= 32'h8000_0FFF) return 1;
        return 2;
    endfunction

    task automatic idle_inputs();
        host_a_valid = 1'b0; host_a_opcode = OpGet; host_a_size = 2'd2; host_a_source = 8'd0;
        host_a_address = 32'h0; host_a_mask = 4'hF; host_a_data = 32'h0; host_d_ready = 1'b0;
        spad_a_ready = 1'b1; spad_d_valid = 1'b0; spad_d_opcode = OpAck; spad_d_size = 2'd2;
        spad_d_source = 8'd0; spad_d_data = 32'h0; spad_d_error = 1'b0;
        uart_a_ready = 1'b1; uart_d_valid = 1'b0; uart_d_opcode = OpAck; uart_d_size = 2'd2;
        uart_d_source = 8'd0; uart_d_data = 32'h0; uart_d_error = 1'b0;
    endtask

    task automatic host_req(input logic [2:0] op, input logic [31:0] addr, input logic [7:0] src, input logic [31:0] data);
        host_a_valid = 1'b1; host_a_opcode = op; host_a_address = addr; host_a_source = src; host_a_data = data;
    endtask

    task automatic spad_rsp(input logic [2:0] op, input logic [7:0] src, input logic [31:0] data);
        spad_d_valid = 1'b1; spad_d_opcode = op; spad_d_source = src; spad_d_data = data; spad_d_error = 1'b0;
    endtask

    task automatic uart_rsp(input logic [2:0] op, input logic [7:0] src, input logic [31:0] data);
        uart_d_valid = 1'b1; uart_d_opcode = op; uart_d_source = src; uart_d_data = data; uart_d_error = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_sys_ni = 1'b0;
        @(negedge clk_sys_i);
        @(negedge clk_sys_i);
        rst_sys_ni = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_sys_ni = 1'b0;
        host_req(OpGet, 32'h0010_0000, 8'd1, 32'h0);
        spad_rsp(OpAckData, 8'd1, 32'h1234_0000);
        host_d_ready = 1'b1;
        #2;
        checks++; if (host_a_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_a_ready: got %0h expected 0", host_a_ready); end
        checks++; if (spad_a_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_spad_a_valid: got %0h expected 0", spad_a_valid); end
        checks++; if (host_d_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_d_valid: got %0h expected 0", host_d_valid); end
        @(negedge clk_sys_i);
        rst_sys_ni = 1'b1;
        host_a_valid = 1'b0;
        #2;
        checks++; if (host_d_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_idle_d_valid: got %0h expected 0", host_d_valid); end
        host_a_valid = 1'b1;
        #1;
        checks++; if (host_a_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_idle_a_ready: got %0h expected 1", host_a_ready); end
        host_a_valid = 1'b0;
    endtask

    task automatic test_spad_get();
        do_reset();
        @(negedge clk_sys_i);
        host_req(OpGet, 32'h0010_0040, 8'd5, 32'h0); host_d_ready = 1'b1;
        #2;
        checks++; if (spad_a_valid !== 1'b1) begin errors++; $display("[TB] FAIL spad_get_a_valid: got %0h expected 1", spad_a_valid); end
        checks++; if (uart_a_valid !== 1'b0) begin errors++; $display("[TB] FAIL spad_get_uart_a_valid: got %0h expected 0", uart_a_valid); end
        checks++; if (host_a_ready !== 1'b1) begin errors++; $display("[TB] FAIL spad_get_a_ready: got %0h expected 1", host_a_ready); end
        @(negedge clk_sys_i);
        host_a_valid = 1'b0; spad_rsp(OpAckData, 8'd5, 32'hDEAD_BEEF);
        #2;
        checks++; if (host_d_valid !== 1'b1) begin errors++; $display("[TB] FAIL spad_get_d_valid: got %0h expected 1", host_d_valid); end
        checks++; if (host_d_opcode !== OpAckData) begin errors++; $display("[TB] FAIL spad_get_d_opcode: got %0h expected %0h", host_d_opcode, OpAckData); end
        checks++; if (host_d_data !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL spad_get_d_data: got %0h expected deadbeef", host_d_data); end
        checks++; if (host_d_error !== 1'b0) begin errors++; $display("[TB] FAIL spad_get_d_error: got %0h expected 0", host_d_error); end
        checks++; if (spad_d_ready !== 1'b1) begin errors++; $display("[TB] FAIL spad_get_d_ready: got %0h expected 1", spad_d_ready); end
        @(negedge clk_sys_i);
        spad_d_valid = 1'b0;
        #2;
        checks++; if (host_d_valid !== 1'b0) begin errors++; $display("[TB] FAIL spad_get_d_done: got %0h expected 0", host_d_valid); end
    endtask

    task automatic test_uart_put();
        do_reset();
        @(negedge clk_sys_i);
        host_req(OpPutFull, 32'h8000_0004, 8'd7, 32'h0000_0041); host_d_ready = 1'b1;
        #2;
        checks++; if (uart_a_valid !== 1'b1) begin errors++; $display("[TB] FAIL uart_put_a_valid: got %0h expected 1", uart_a_valid); end
        checks++; if (spad_a_valid !== 1'b0) begin errors++; $display("[TB] FAIL uart_put_spad_a_valid: got %0h expected 0", spad_a_valid); end
        checks++; if (uart_a_data !== 32'h41) begin errors++; $display("[TB] FAIL uart_put_a_data: got %0h expected 41", uart_a_data); end
        @(negedge clk_sys_i);
        host_a_valid = 1'b0; uart_rsp(OpAck, 8'd7, 32'h0);
        #2;
        checks++; if (host_d_valid !== 1'b1) begin errors++; $display("[TB] FAIL uart_put_d_valid: got %0h expected 1", host_d_valid); end
        checks++; if (host_d_opcode !== OpAck) begin errors++; $display("[TB] FAIL uart_put_d_opcode: got %0h expected %0h", host_d_opcode, OpAck); end
        checks++; if (host_d_source !== 8'd7) begin errors++; $display("[TB] FAIL uart_put_d_source: got %0h expected 7", host_d_source); end
        @(negedge clk_sys_i);
        uart_d_valid = 1'b0;
    endtask

    task automatic test_err();
        do_reset();
        @(negedge clk_sys_i);
        host_req(OpGet, 32'h4000_0000, 8'd3, 32'h0); host_d_ready = 1'b0;
        #2;
        checks++; if (host_a_ready !== 1'b1) begin errors++; $display("[TB] FAIL err_accept: got %0h expected 1", host_a_ready); end
        checks++; if ((spad_a_valid | uart_a_valid) !== 1'b0) begin errors++; $display("[TB] FAIL err_dev_a_valid: got %0h expected 0", spad_a_valid | uart_a_valid); end
        checks++; if (host_d_valid !== 1'b0) begin errors++; $display("[TB] FAIL err_d_early: got %0h expected 0", host_d_valid); end
        @(negedge clk_sys_i);
        host_req(OpPutFull, 32'h4000_0100, 8'd9, 32'h77);
        #2;
        checks++; if (host_d_valid !== 1'b1) begin errors++; $display("[TB] FAIL err_d_valid: got %0h expected 1", host_d_valid); end
        checks++; if (host_d_error !== 1'b1) begin errors++; $display("[TB] FAIL err_d_error: got %0h expected 1", host_d_error); end
        checks++; if (host_d_data !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL err_d_data: got %0h expected ffffffff", host_d_data); end
        checks++; if (host_d_source !== 8'd3) begin errors++; $display("[TB] FAIL err_d_source: got %0h expected 3", host_d_source); end
        checks++; if (host_d_opcode !== OpAckData) begin errors++; $display("[TB] FAIL err_d_opcode: got %0h expected %0h", host_d_opcode, OpAckData); end
        checks++; if (host_a_ready !== 1'b0) begin errors++; $display("[TB] FAIL err_second_held: got %0h expected 0", host_a_ready); end
        @(negedge clk_sys_i);
        host_d_ready = 1'b1;
        #2;
        checks++; if (host_a_ready !== 1'b0) begin errors++; $display("[TB] FAIL err_held_on_hs: got %0h expected 0", host_a_ready); end
        @(negedge clk_sys_i);
        #2;
        checks++; if (host_a_ready !== 1'b1) begin errors++; $display("[TB] FAIL err_second_accept: got %0h expected 1", host_a_ready); end
        checks++; if (host_d_valid !== 1'b0) begin errors++; $display("[TB] FAIL err_d_cleared: got %0h expected 0", host_d_valid); end
        @(negedge clk_sys_i);
        host_a_valid = 1'b0;
        #2;
        checks++; if (host_d_opcode !== OpAck || host_d_source !== 8'd9) begin errors++; $display("[TB] FAIL err_put_rsp: got op %0h src %0h expected op 0 src 9", host_d_opcode, host_d_source); end
    endtask

    task automatic test_max_outstanding();
        do_reset();
        for (int i = 0; i < MaxOut; i++) begin
            @(negedge clk_sys_i);
            host_req(OpGet, 32'h0010_0000 + 32'(i * 4), 8'(i), 32'h0); host_d_ready = 1'b1;
            #2;
            checks++; if (host_a_ready !== 1'b1) begin errors++; $display("[TB] FAIL max_accept_%0d: got %0h expected 1", i, host_a_ready); end
        end
        @(negedge clk_sys_i);
        host_req(OpGet, 32'h0010_0010, 8'd4, 32'h0);
        #2;
        checks++; if (host_a_ready !== 1'b0) begin errors++; $display("[TB] FAIL max_stall_ready: got %0h expected 0", host_a_ready); end
        checks++; if (spad_a_valid !== 1'b0) begin errors++; $display("[TB] FAIL max_stall_valid: got %0h expected 0", spad_a_valid); end
        @(negedge clk_sys_i);
        spad_rsp(OpAckData, 8'd0, 32'h0000_0A00);
        #2;
        checks++; if (host_d_valid !== 1'b1) begin errors++; $display("[TB] FAIL max_rsp_valid: got %0h expected 1", host_d_valid); end
        checks++; if (host_a_ready !== 1'b0) begin errors++; $display("[TB] FAIL max_release_same: got %0h expected 0", host_a_ready); end
        @(negedge clk_sys_i);
        spad_d_valid = 1'b0;
        #2;
        checks++; if (host_a_ready !== 1'b1 || spad_a_valid !== 1'b1) begin errors++; $display("[TB] FAIL max_release_next: got ready %0h valid %0h expected 1 1", host_a_ready, spad_a_valid); end
        @(negedge clk_sys_i);
        host_a_valid = 1'b0;
    endtask

    task automatic test_target_switch();
        do_reset();
        @(negedge clk_sys_i);
        host_req(OpGet, 32'h0010_0080, 8'd1, 32'h0); host_d_ready = 1'b1;
        #2;
        checks++; if (host_a_ready !== 1'b1) begin errors++; $display("[TB] FAIL switch_first: got %0h expected 1", host_a_ready); end
        @(negedge clk_sys_i);
        host_req(OpPutFull, 32'h8000_0008, 8'd2, 32'h55);
        uart_rsp(OpAckData, 8'd2, 32'hBAD0_BAD0);
        #2;
        checks++; if (uart_a_valid !== 1'b0 || host_a_ready !== 1'b0) begin errors++; $display("[TB] FAIL switch_held: got valid %0h ready %0h expected 0 0", uart_a_valid, host_a_ready); end
        checks++; if (host_d_valid !== 1'b0) begin errors++; $display("[TB] FAIL switch_spurious: got %0h expected 0", host_d_valid); end
        checks++; if (uart_d_ready !== 1'b0) begin errors++; $display("[TB] FAIL switch_uart_d_ready: got %0h expected 0", uart_d_ready); end
        @(negedge clk_sys_i);
        spad_rsp(OpAckData, 8'd1, 32'h1234_5678);
        #2;
        checks++; if (host_d_valid !== 1'b1 || host_d_data !== 32'h1234_5678) begin errors++; $display("[TB] FAIL switch_spad_rsp: got valid %0h data %0h expected 1 12345678", host_d_valid, host_d_data); end
        checks++; if (uart_a_valid !== 1'b0) begin errors++; $display("[TB] FAIL switch_held_on_hs: got %0h expected 0", uart_a_valid); end
        @(negedge clk_sys_i);
        spad_d_valid = 1'b0; uart_d_valid = 1'b0;
        #2;
        checks++; if (uart_a_valid !== 1'b1 || host_a_ready !== 1'b1) begin errors++; $display("[TB] FAIL switch_accept: got valid %0h ready %0h expected 1 1", uart_a_valid, host_a_ready); end
        @(negedge clk_sys_i);
        host_a_valid = 1'b0; uart_rsp(OpAck, 8'd2, 32'h0);
        #2;
        checks++; if (host_d_valid !== 1'b1 || host_d_source !== 8'd2) begin errors++; $display("[TB] FAIL switch_uart_rsp: got valid %0h src %0h expected 1 2", host_d_valid, host_d_source); end
        @(negedge clk_sys_i);
        uart_d_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        @(negedge clk_sys_i);
        host_req(OpGet, 32'h0010_0100, 8'd1, 32'h0);
        @(negedge clk_sys_i);
        host_req(OpGet, 32'h0010_0104, 8'd2, 32'h0);
        @(negedge clk_sys_i);
        host_req(OpGet, 32'h0010_0108, 8'd3, 32'h0);
        spad_rsp(OpAckData, 8'd1, 32'h1111_1111);
        #2;
        checks++; if (host_d_valid !== 1'b1) begin errors++; $display("[TB] FAIL areset_pre_d_valid: got %0h expected 1", host_d_valid); end
        rst_sys_ni = 1'b0;
        #1;
        checks++; if (host_a_ready !== 1'b0 || spad_a_valid !== 1'b0) begin errors++; $display("[TB] FAIL areset_a_side: got ready %0h valid %0h expected 0 0", host_a_ready, spad_a_valid); end
        checks++; if (host_d_valid !== 1'b0 || spad_d_ready !== 1'b0) begin errors++; $display("[TB] FAIL areset_d_side: got valid %0h ready %0h expected 0 0", host_d_valid, spad_d_ready); end
        @(negedge clk_sys_i);
        rst_sys_ni = 1'b1;
        host_req(OpPutFull, 32'h8000_0010, 8'd5, 32'hA5); host_d_ready = 1'b1;
        #2;
        checks++; if (host_a_ready !== 1'b1 || uart_a_valid !== 1'b1) begin errors++; $display("[TB] FAIL areset_fresh_accept: got ready %0h valid %0h expected 1 1", host_a_ready, uart_a_valid); end
        checks++; if (host_d_valid !== 1'b0) begin errors++; $display("[TB] FAIL areset_abandoned: got %0h expected 0", host_d_valid); end
        @(negedge clk_sys_i);
        host_a_valid = 1'b0; uart_rsp(OpAck, 8'd5, 32'h0);
        #2;
        checks++; if (host_d_valid !== 1'b1 || host_d_source !== 8'd5 || host_d_opcode !== OpAck) begin errors++; $display("[TB] FAIL areset_uart_rsp: got valid %0h src %0h op %0h expected 1 5 0", host_d_valid, host_d_source, host_d_opcode); end
        @(negedge clk_sys_i);
        spad_d_valid = 1'b0; uart_d_valid = 1'b0;
    endtask

    task automatic test_random();
        rsp_t ref_q[$];
        rsp_t spad_q[$];
        rsp_t uart_q[$];
        logic [31:0] ref_mem [0:255];
        logic [31:0] dev_mem [0:255];
        int ref_out, ref_tgt, tgt, idx;
        bit pending, spad_hold, uart_hold, exp_stall, exp_ready, exp_dv, acc, dh;
        logic [2:0] op;
        logic [31:0] addr;
        rsp_t e, r;
        do_reset();
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = 32'h0;
            dev_mem[i] = 32'h0;
        end
        ref_out = 0; ref_tgt = 0; pending = 0; spad_hold = 0; uart_hold = 0;
        for (int cyc = 0; cyc < 2500; cyc++) begin
            @(negedge clk_sys_i);
            if (!pending) host_a_valid = 1'b0;
            if (!pending && cyc < 2300 && $urandom_range(0, 2) != 0) begin
                case ($urandom_range(0, 2))
                    0: op = OpGet;
                    1: op = OpPutFull;
                    default: op = OpPutPartial;
                endcase
                case ($urandom_range(0, 3))
                    0, 1: begin
                        addr = 32'h0010_0000 + 32'($urandom_range(0, 255)) * 4;
                        if ($urandom_range(0, 7) == 0) addr = 32'h0010_FFFC;
                        if (op == OpPutPartial) op = OpPutFull;
                    end
                    2: addr = 32'h8000_0000 + 32'($urandom_range(0, 1023)) * 4;
                    default: begin
                        case ($urandom_range(0, 3))
                            0: addr = 32'h4000_0000 + 32'($urandom_range(0, 4095)) * 4;
                            1: addr = 32'h0011_0000;
                            2: addr = 32'h8000_1000;
                            default: addr = 32'h000F_FFFC;
                        endcase
                    end
                endcase
                host_req(op, addr, 8'($urandom_range(0, 255)), $urandom);
                pending = 1;
            end
            host_d_ready = ($urandom_range(0, 3) != 0);
            spad_a_ready = ($urandom_range(0, 3) != 0);
            uart_a_ready = ($urandom_range(0, 3) != 0);
            if (spad_q.size() > 0 && (spad_hold || $urandom_range(0, 1) == 1)) begin
                spad_hold = 1; spad_rsp(spad_q[0].op, spad_q[0].src, spad_q[0].data);
            end else spad_d_valid = 1'b0;
            if (uart_q.size() > 0 && (uart_hold || $urandom_range(0, 1) == 1)) begin
                uart_hold = 1; uart_rsp(uart_q[0].op, uart_q[0].src, uart_q[0].data);
            end else uart_d_valid = 1'b0;
            #2;
            tgt = tb_decode(host_a_address);
            exp_stall = (ref_out == MaxOut) || (ref_out != 0 && tgt != ref_tgt);
            if (tgt == 0) exp_ready = !exp_stall && spad_a_ready;
            else if (tgt == 1) exp_ready = !exp_stall && uart_a_ready;
            else exp_ready = !exp_stall && (ref_out == 0);
            if (host_a_valid) begin
                checks++; if (host_a_ready !== exp_ready) begin errors++; $display("[TB] FAIL rnd_a_ready cyc %0d: got %0h expected %0h", cyc, host_a_ready, exp_ready); end
            end
            checks++; if (spad_a_valid !== (host_a_valid && !exp_stall && tgt == 0)) begin errors++; $display("[TB] FAIL rnd_spad_a_valid cyc %0d: got %0h expected %0h", cyc, spad_a_valid, host_a_valid && !exp_stall && tgt == 0); end
            checks++; if (uart_a_valid !== (host_a_valid && !exp_stall && tgt == 1)) begin errors++; $display("[TB] FAIL rnd_uart_a_valid cyc %0d: got %0h expected %0h", cyc, uart_a_valid, host_a_valid && !exp_stall && tgt == 1); end
            exp_dv = (ref_out != 0) && (ref_tgt == 2 || (ref_tgt == 0 && spad_d_valid) || (ref_tgt == 1 && uart_d_valid));
            checks++; if (host_d_valid !== exp_dv) begin errors++; $display("[TB] FAIL rnd_d_valid cyc %0d: got %0h expected %0h", cyc, host_d_valid, exp_dv); end
            if (host_d_valid && ref_q.size() > 0) begin
                e = ref_q[0];
                checks++; if (host_d_opcode !== e.op || host_d_source !== e.src || host_d_error !== e.err) begin errors++; $display("[TB] FAIL rnd_d_fields cyc %0d: got op %0h src %0h err %0h expected op %0h src %0h err %0h", cyc, host_d_opcode, host_d_source, host_d_error, e.op, e.src, e.err); end
                if (e.chk) begin
                    checks++; if (host_d_data !== e.data) begin errors++; $display("[TB] FAIL rnd_d_data cyc %0d: got %0h expected %0h", cyc, host_d_data, e.data); end
                end
            end
            if (spad_d_valid) begin
                checks++; if (spad_d_ready !== (host_d_ready && ref_out != 0 && ref_tgt == 0)) begin errors++; $display("[TB] FAIL rnd_spad_d_ready cyc %0d: got %0h", cyc, spad_d_ready); end
            end
            acc = host_a_valid && host_a_ready;
            dh = host_d_valid && host_d_ready;
            if (spad_a_valid && spad_a_ready) begin
                r.src = spad_a_source; r.err = 1'b0; r.chk = 1'b0;
                if (spad_a_opcode == OpGet) begin
                    r.op = OpAckData; r.data = dev_mem[spad_a_address[9:2]];
                end else begin
                    r.op = OpAck; r.data = 32'h0; dev_mem[spad_a_address[9:2]] = spad_a_data;
                end
                spad_q.push_back(r);
            end
            if (uart_a_valid && uart_a_ready) begin
                r.src = uart_a_source; r.err = 1'b0; r.chk = 1'b0;
                r.op = (uart_a_opcode == OpGet) ? OpAckData : OpAck;
                r.data = 32'hC0DE_0000 | {20'h0, uart_a_address[11:0]};
                uart_q.push_back(r);
            end
            if (spad_d_valid && spad_d_ready) begin void'(spad_q.pop_front()); spad_hold = 0; end
            if (uart_d_valid && uart_d_ready) begin void'(uart_q.pop_front()); uart_hold = 0; end
            if (dh && ref_q.size() > 0) void'(ref_q.pop_front());
            if (acc) begin
                e.src = host_a_source; e.err = 1'b0; e.chk = 1'b0; e.data = 32'h0;
                e.op = (host_a_opcode == OpGet) ? OpAckData : OpAck;
                idx = int'((host_a_address - 32'h0010_0000) / 4) % 256;
                if (tgt == 0) begin
                    if (host_a_opcode == OpGet) begin e.data = ref_mem[idx]; e.chk = 1'b1; end
                    else ref_mem[idx] = host_a_data;
                end else if (tgt == 1) begin
                    if (host_a_opcode == OpGet) begin e.data = 32'hC0DE_0000 + (host_a_address - 32'h8000_0000); e.chk = 1'b1; end
                end else begin
                    e.err = 1'b1; e.data = 32'hFFFF_FFFF; e.chk = 1'b1;
                end
                ref_q.push_back(e);
                ref_tgt = tgt;
                pending = 0;
            end
            ref_out = ref_out + (acc ? 1 : 0) - (dh ? 1 : 0);
        end
        checks++; if (ref_q.size() != 0 || pending) begin errors++; $display("[TB] FAIL rnd_drain: got %0d outstanding expected 0", ref_q.size() + (pending ? 1 : 0)); end
        @(negedge clk_sys_i);
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_spad_get();
        test_uart_put();
        test_err();
        test_max_outstanding();
        test_target_switch();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
